ntt_stage_sequencer: RTL

NTT_STAGE_SEQUENCER -- requirements
Module: ntt_stage_sequencer

---
 rtl/ntt_stage_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ntt_stage_sequencer.sv
// Address/control sequencer for an in-place radix-4/radix-2 NTT and INTT.
// Define NTT_SEQ_ABORT_EN to add the abort input.
module ntt_stage_sequencer #(
    parameter int LOG_N    = 9,
    parameter int NTT_LAT  = 7,
    parameter int INTT_LAT = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
`ifdef NTT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [2:0]       stage,
    output logic             radix2,
    output logic [LOG_N-1:0] rd_addr0,
    output logic [LOG_N-1:0] rd_addr1,
    output logic [LOG_N-1:0] rd_addr2,
    output logic [LOG_N-1:0] rd_addr3,
    output logic             rd_en,
    output logic [LOG_N-1:0] wr_addr0,
    output logic [LOG_N-1:0] wr_addr1,
    output logic [LOG_N-1:0] wr_addr2,
    output logic [LOG_N-1:0] wr_addr3,
    output logic             wr_en,
    output logic [LOG_N-3:0] tf_index
);
    localparam int GW  = LOG_N - 2;
    localparam int N4  = 1 << GW;
    localparam int R4  = LOG_N / 2;
    localparam int ODD = LOG_N % 2;
    localparam int NS  = R4 + ODD;
    localparam int W   = 4 * LOG_N + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           g_q, g_d;
    logic [2:0]              stage_q, stage_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [4:0]              lat_q, lat_d;
    logic                    mode_q, mode_d;
    logic                    abort_q, abort_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    radix2_q, radix2_d;
    logic                    rd_en_q, rd_en_d;
    logic [3:0][LOG_N-1:0]   rd_q, rd_d, addr;
    logic [GW-1:0]           tf_q, tf_d, tf;
    logic [W-1:0]            line_q [32];
    logic [W-1:0]            line_d [32];
    logic [W-1:0]            tap;
    logic                    abort_in;

`ifdef NTT_SEQ_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    function automatic logic is_r2(input logic [2:0] s, input logic m);
        if (ODD == 0) return 1'b0;
        return m ? (s == 3'd0) : (s == 3'(R4));
    endfunction

    // Radix-4 stride exponent: NTT walks N/4 downwards, INTT walks 1 upwards.
    task automatic gen(
        input  logic [2:0]            s,
        input  logic                  m,
        input  logic [GW-1:0]         g,
        output logic [3:0][LOG_N-1:0] a,
        output logic [GW-1:0]         t
    );
        int k;
        logic [GW-1:0]    hi, lo;
        logic [LOG_N-1:0] b;
        k  = m ? 2 * (int'(s) - ODD) : GW - 2 * int'(s);
        if (k < 0) k = 0;
        hi = g >> k;
        lo = g & GW'((1 << k) - 1);
        b  = (LOG_N'(hi) << (k + 2)) | LOG_N'(lo);
        for (int i = 0; i < 4; i++) begin
            if (is_r2(s, m)) a[i] = (LOG_N'(g) << 2) + LOG_N'(i);
            else             a[i] = b + (LOG_N'(i) << k);
        end
        t = is_r2(s, m) ? g : hi;
    endtask

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        mode_d  = mode_q;
        abort_d = abort_q;
        unique case (state_q)
            IDLE: if (start) begin
                mode_d  = mode;
                lat_d   = mode ? 5'(INTT_LAT) : 5'(NTT_LAT);
                state_d = READ;
                g_d     = '0;
                stage_d = '0;
                abort_d = 1'b0;
            end
            READ: if (abort_in || g_q == GW'(N4 - 1)) begin
                state_d = DRAIN;
                cnt_d   = '0;
                abort_d = abort_in;
            end else begin
                g_d = g_q + 1'b1;
            end
            DRAIN: if (cnt_q == lat_q - 5'd1) begin
                if (abort_q || stage_q == 3'(NS - 1)) begin
                    state_d = abort_q ? IDLE : DONE;
                    stage_d = '0;
                end else begin
                    stage_d = stage_q + 3'd1;
                    g_d     = '0;
                    state_d = READ;
                end
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d == READ) || (state_d == DRAIN);
        done_d   = (state_d == DONE);
        rd_en_d  = (state_d == READ);
        radix2_d = busy_d && is_r2(stage_d, mode_d);
        gen(stage_d, mode_d, g_d, addr, tf);
        rd_d = rd_en_d ? addr : '0;
        tf_d = rd_en_d ? tf : '0;
        line_d[0] = {rd_en_q, rd_q};
        for (int i = 1; i < 32; i++) line_d[i] = line_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            g_q      <= '0;
            stage_q  <= '0;
            cnt_q    <= '0;
            lat_q    <= 5'(NTT_LAT);
            mode_q   <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            radix2_q <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_q     <= '0;
            tf_q     <= '0;
            for (int i = 0; i < 32; i++) line_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            mode_q   <= mode_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            radix2_q <= radix2_d;
            rd_en_q  <= rd_en_d;
            rd_q     <= rd_d;
            tf_q     <= tf_d;
            for (int i = 0; i < 32; i++) line_q[i] <= line_d[i];
        end
    end

    assign tap      = line_q[lat_q - 5'd1];
    assign busy     = busy_q;
    assign done     = done_q;
    assign stage    = stage_q;
    assign radix2   = radix2_q;
    assign rd_en    = rd_en_q;
    assign rd_addr0 = rd_q[0];
    assign rd_addr1 = rd_q[1];
    assign rd_addr2 = rd_q[2];
    assign rd_addr3 = rd_q[3];
    assign tf_index = tf_q;
    assign wr_en    = tap[W-1];
    assign wr_addr0 = tap[LOG_N-1:0];
    assign wr_addr1 = tap[2*LOG_N-1:LOG_N];
    assign wr_addr2 = tap[3*LOG_N-1:2*LOG_N];
    assign wr_addr3 = tap[4*LOG_N-1:3*LOG_N];
endmodule
